// File: rtl/result_readout.sv
// result_readout: post-run readout of the CPU result matrix.
// Snapshots the performance counters on the rising edge of done, then reads the
// result region of data memory one byte at a time, assembles big-endian signed
// 32-bit words and streams them out on a valid/ready interface.
module result_readout #(
    parameter int M      = 3,
    parameter int N      = 4,
    parameter int N2     = 1,
    parameter int ADDR_W = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     reset_n,
    input  logic                     done,
    input  logic [15:0]              clock_count,
    input  logic [15:0]              instr_cnt,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [7:0]               mem_rdata,
    output logic signed [31:0]       out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_idx,
    output logic                     out_last,
    output logic [15:0]              snap_cycles,
    output logic [15:0]              snap_instr,
    output logic                     busy,
    output logic                     finished
);

    localparam int                RES_BASE = M*N*4 + N*N2*4;
    localparam int                NWORDS   = M*N2;
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(RES_BASE);
    localparam logic [15:0]       LAST_W   = 16'(NWORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WT,
        S_PR,
        S_FIN
    } state_t;

    state_t      state;
    logic        done_q;
    logic        start;
    logic [1:0]  b;

    // Read-return pipeline: which lane the byte arriving this cycle belongs to.
    logic        rd_vld_p1;
    logic [1:0]  rd_lane_p1;

    // Place one byte into its big-endian lane: lane 0 (lowest address) is the MSB.
    function automatic logic signed [31:0] lane_insert(
        input logic signed [31:0] word,
        input logic [1:0]         lane,
        input logic [7:0]         byte_v
    );
        logic signed [31:0] r;
        r = word;
        case (lane)
            2'd0:    r[31:24] = byte_v;
            2'd1:    r[23:16] = byte_v;
            2'd2:    r[15:8]  = byte_v;
            default: r[7:0]   = byte_v;
        endcase
        return r;
    endfunction

    assign start = done & ~done_q;

    // Previous-cycle copy of done for rising-edge detection.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done;
        end
    end

    // Control FSM with registered outputs; out_idx doubles as the word pointer.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            b           <= 2'd0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            out_valid   <= 1'b0;
            out_idx     <= 16'd0;
            out_last    <= 1'b0;
            snap_cycles <= 16'd0;
            snap_instr  <= 16'd0;
            busy        <= 1'b0;
            finished    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        snap_cycles <= clock_count;
                        snap_instr  <= instr_cnt;
                        out_idx     <= 16'd0;
                        out_last    <= 1'b0;
                        b           <= 2'd0;
                        mem_rd      <= 1'b1;
                        mem_addr    <= BASE_A;
                        busy        <= 1'b1;
                        state       <= S_RD;
                    end
                end
                S_RD: begin
                    if (b == 2'd3) begin
                        mem_rd <= 1'b0;
                        state  <= S_WT;
                    end else begin
                        b        <= b + 2'd1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                S_WT: begin
                    out_valid <= 1'b1;
                    out_last  <= (out_idx == LAST_W);
                    state     <= S_PR;
                end
                S_PR: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_idx == LAST_W) begin
                            busy     <= 1'b0;
                            finished <= 1'b1;
                            state    <= S_FIN;
                        end else begin
                            // Last address was base+4w+3, so the next word starts one byte on.
                            out_idx  <= out_idx + 16'd1;
                            b        <= 2'd0;
                            mem_rd   <= 1'b1;
                            mem_addr <= mem_addr + ADDR_W'(1);
                            state    <= S_RD;
                        end
                    end
                end
                S_FIN: begin
                    if (!done) begin
                        finished <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Stage p1: remember which lane was issued so the returning byte can be placed.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_p1  <= 1'b0;
            rd_lane_p1 <= 2'd0;
        end else begin
            rd_vld_p1  <= mem_rd;
            rd_lane_p1 <= b;
        end
    end

    // Stage p2: capture the returned byte into the output word.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            out_data <= '0;
        end else if (rd_vld_p1) begin
            out_data <= lane_insert(out_data, rd_lane_p1, mem_rdata);
        end
    end

endmodule

// File: tb/tb_result_readout.sv
// Testbench for result_readout: byte-memory model with one-cycle read latency,
// stream monitor, and a word-level reference model built from memory contents.
module tb_result_readout;

    logic               CLOCK_50 = 1'b0;
    logic               reset_n;
    logic               done, done2;
    logic [15:0]        clock_count, instr_cnt;
    logic               mem_rd, mem_rd2;
    logic [15:0]        mem_addr, mem_addr2;
    logic [7:0]         mem_rdata, mem_rdata2;
    logic signed [31:0] out_data, out_data2;
    logic               out_valid, out_valid2;
    logic               out_ready, out_ready2;
    logic [15:0]        out_idx, out_idx2;
    logic               out_last, out_last2;
    logic [15:0]        snap_cycles, snap_instr, snap_cycles2, snap_instr2;
    logic               busy, busy2, finished, finished2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] mem  [0:255];
    logic [7:0] mem2 [0:255];

    logic [15:0]        rd_addr_q[$];
    int                 rd_cyc_q[$];
    logic signed [31:0] acc_data_q[$];
    logic [15:0]        acc_idx_q[$];
    logic               acc_last_q[$];
    logic [15:0]        rd_addr2_q[$];
    logic signed [31:0] acc_data2_q[$];
    logic [15:0]        acc_idx2_q[$];
    logic               acc_last2_q[$];

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    result_readout #(.M(3), .N(4), .N2(1), .ADDR_W(16)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .done(done),
        .clock_count(clock_count), .instr_cnt(instr_cnt),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_last(out_last),
        .snap_cycles(snap_cycles), .snap_instr(snap_instr),
        .busy(busy), .finished(finished)
    );

    result_readout #(.M(2), .N(3), .N2(2), .ADDR_W(16)) dut2 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .done(done2),
        .clock_count(clock_count), .instr_cnt(instr_cnt),
        .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_idx(out_idx2), .out_last(out_last2),
        .snap_cycles(snap_cycles2), .snap_instr(snap_instr2),
        .busy(busy2), .finished(finished2)
    );

    // Data memories: read byte valid the cycle after the strobe.
    always @(posedge CLOCK_50) begin
        if (mem_rd)  mem_rdata  <= mem[mem_addr[7:0]];
        if (mem_rd2) mem_rdata2 <= mem2[mem_addr2[7:0]];
    end

    // Monitor: log read addresses and every accepted word.
    always @(negedge CLOCK_50) begin
        if (mem_rd) begin
            rd_addr_q.push_back(mem_addr);
            rd_cyc_q.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            acc_data_q.push_back(out_data);
            acc_idx_q.push_back(out_idx);
            acc_last_q.push_back(out_last);
        end
        if (mem_rd2) rd_addr2_q.push_back(mem_addr2);
        if (out_valid2 && out_ready2) begin
            acc_data2_q.push_back(out_data2);
            acc_idx2_q.push_back(out_idx2);
            acc_last2_q.push_back(out_last2);
        end
    end

    // Reference: result word at byte address a, big-endian, signed.
    function automatic logic signed [31:0] exp_word(input int a, input bit second);
        if (second) return {mem2[a], mem2[a+1], mem2[a+2], mem2[a+3]};
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic fill_random(input int lo, input int hi, input bit second);
        for (int i = lo; i <= hi; i++) begin
            if (second) mem2[i] = 8'($urandom);
            else        mem[i]  = 8'($urandom);
        end
    endtask

    task automatic wait_finished(output int fc);
        int n;
        n = 0;
        while (!finished && n < 300) begin
            tick();
            n++;
        end
        fc = cyc;
        tests++;
        if (finished !== 1'b1) begin
            fails++;
            $display("FAIL finish_timeout: finished=%b after %0d cycles, required 1", finished, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        tests++;
        if ({mem_rd, mem_addr, out_data, out_valid, out_idx, out_last, snap_cycles,
             snap_instr, busy, finished} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: rd=%b addr=%0d data=%0d vld=%b idx=%0d last=%b snap=%0d/%0d busy=%b fin=%b, required all 0",
                     mem_rd, mem_addr, out_data, out_valid, out_idx, out_last, snap_cycles, snap_instr, busy, finished);
        end
        tests++;
        if ({mem_rd2, out_valid2, busy2, finished2, snap_cycles2} !== '0) begin
            fails++;
            $display("FAIL reset_outputs2: rd=%b vld=%b busy=%b fin=%b snap=%0d, required 0",
                     mem_rd2, out_valid2, busy2, finished2, snap_cycles2);
        end
        tick(); tick();
        #2 reset_n = 1'b1;
        tick(); tick();
        tests++;
        if ({mem_rd, out_valid, busy, finished} !== 4'b0) begin
            fails++;
            $display("FAIL idle_after_reset: rd=%b vld=%b busy=%b fin=%b, required 0", mem_rd, out_valid, busy, finished);
        end
    endtask

    task automatic test_nominal();
        int rb, base, n, fc;
        logic signed [31:0] want [3];
        want[0] = 32'sd30; want[1] = -32'sd10; want[2] = 32'sd256;
        for (int i = 64; i < 76; i++) mem[i] = 8'h00;
        mem[67] = 8'h1E;
        mem[68] = 8'hFF; mem[69] = 8'hFF; mem[70] = 8'hFF; mem[71] = 8'hF6;
        mem[74] = 8'h01;
        clock_count = 16'd412; instr_cnt = 16'd150; out_ready = 1'b1;
        rb = rd_addr_q.size(); base = acc_data_q.size();
        done = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!out_valid && n < 20);
        tests++;
        if (n != 6) begin
            fails++;
            $display("FAIL nominal_latency: out_valid after %0d cycles, required 6", n);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL nominal_busy: busy=%b, required 1", busy);
        end
        wait_finished(fc);
        tests++;
        if (acc_data_q.size() - base != 3) begin
            fails++;
            $display("FAIL nominal_count: %0d words, required 3", acc_data_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (acc_data_q[base+i] !== want[i] || acc_idx_q[base+i] !== 16'(i) ||
                    acc_last_q[base+i] !== (i == 2)) begin
                    fails++;
                    $display("FAIL nominal_word%0d: data=%0d idx=%0d last=%b, required data=%0d idx=%0d last=%b",
                             i, acc_data_q[base+i], acc_idx_q[base+i], acc_last_q[base+i], want[i], i, (i == 2));
                end
            end
        end
        tests++;
        if (rd_addr_q.size() - rb != 12) begin
            fails++;
            $display("FAIL nominal_addr_count: %0d reads, required 12", rd_addr_q.size() - rb);
        end else begin
            for (int i = 0; i < 12; i++) begin
                tests++;
                if (rd_addr_q[rb+i] !== 16'(64 + i)) begin
                    fails++;
                    $display("FAIL nominal_addr%0d: addr=%0d, required %0d", i, rd_addr_q[rb+i], 64 + i);
                end
            end
            tests++;
            if (fc - rd_cyc_q[rb] != 18) begin
                fails++;
                $display("FAIL nominal_fin_latency: FIN %0d cycles after first RD, required 18", fc - rd_cyc_q[rb]);
            end
        end
        tests++;
        if (snap_cycles !== 16'd412 || snap_instr !== 16'd150 || busy !== 1'b0) begin
            fails++;
            $display("FAIL nominal_snap: cycles=%0d instr=%0d busy=%b, required 412 150 0", snap_cycles, snap_instr, busy);
        end
        done = 1'b0;
        tick(); tick();
        tests++;
        if (finished !== 1'b0) begin
            fails++;
            $display("FAIL nominal_return_idle: finished=%b, required 0", finished);
        end
    endtask

    task automatic test_backpressure();
        int base, rb, n, fc;
        logic signed [31:0] hold_d;
        logic [15:0]        hold_i;
        fill_random(64, 75, 1'b0);
        out_ready = 1'b1;
        base = acc_data_q.size();
        done = 1'b1;
        n = 0;
        while (!(out_valid && out_idx == 16'd1) && n < 50) begin tick(); n++; end
        tests++;
        if (!(out_valid && out_idx == 16'd1)) begin
            fails++;
            $display("FAIL bp_reach_idx1: vld=%b idx=%0d, required 1 and 1", out_valid, out_idx);
        end
        hold_d = out_data; hold_i = out_idx;
        tests++;
        if (hold_d !== exp_word(68, 1'b0)) begin
            fails++;
            $display("FAIL bp_word1_value: data=%0d, required %0d", hold_d, exp_word(68, 1'b0));
        end
        out_ready = 1'b0;
        rb = rd_addr_q.size();
        for (int k = 0; k < 7; k++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_data !== hold_d || out_idx !== hold_i || mem_rd !== 1'b0) begin
                fails++;
                $display("FAIL bp_stall%0d: vld=%b data=%0d idx=%0d rd=%b, required 1 %0d %0d 0",
                         k, out_valid, out_data, out_idx, mem_rd, hold_d, hold_i);
            end
        end
        tests++;
        if (rd_addr_q.size() != rb) begin
            fails++;
            $display("FAIL bp_no_reads: %0d reads during stall, required 0", rd_addr_q.size() - rb);
        end
        out_ready = 1'b1;
        wait_finished(fc);
        tests++;
        if (acc_data_q.size() - base != 3) begin
            fails++;
            $display("FAIL bp_count: %0d words, required 3", acc_data_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (acc_data_q[base+i] !== exp_word(64 + 4*i, 1'b0) || acc_idx_q[base+i] !== 16'(i)) begin
                    fails++;
                    $display("FAIL bp_word%0d: data=%0d idx=%0d, required %0d %0d",
                             i, acc_data_q[base+i], acc_idx_q[base+i], exp_word(64 + 4*i, 1'b0), i);
                end
            end
        end
        done = 1'b0;
        tick(); tick();
    endtask

    task automatic test_done_held();
        int base, n, fc;
        logic [15:0] cc0, ic0, cc1, ic1;
        for (int pass = 0; pass < 2; pass++) begin
            fill_random(64, 75, 1'b0);
            cc0 = 16'($urandom); ic0 = 16'($urandom);
            clock_count = cc0; instr_cnt = ic0; out_ready = 1'b1;
            base = acc_data_q.size();
            done = 1'b1;
            n = 0;
            while (!finished && n < 100) begin
                tick(); n++;
                clock_count = 16'($urandom); instr_cnt = 16'($urandom);
            end
            for (int k = 0; k < 10; k++) begin
                tick();
                clock_count = 16'($urandom); instr_cnt = 16'($urandom);
            end
            cc1 = snap_cycles; ic1 = snap_instr;
            tests++;
            if (finished !== 1'b1 || acc_data_q.size() - base != 3) begin
                fails++;
                $display("FAIL held_one_pass%0d: finished=%b words=%0d, required 1 and 3",
                         pass, finished, acc_data_q.size() - base);
            end else begin
                for (int i = 0; i < 3; i++) begin
                    tests++;
                    if (acc_data_q[base+i] !== exp_word(64 + 4*i, 1'b0)) begin
                        fails++;
                        $display("FAIL held_word%0d_%0d: data=%0d, required %0d",
                                 pass, i, acc_data_q[base+i], exp_word(64 + 4*i, 1'b0));
                    end
                end
            end
            tests++;
            if (cc1 !== cc0 || ic1 !== ic0) begin
                fails++;
                $display("FAIL held_snap%0d: cycles=%0d instr=%0d, required %0d %0d", pass, cc1, ic1, cc0, ic0);
            end
            done = 1'b0;
            tick(); tick();
            fc = 0;
        end
        tests++;
        if (finished !== 1'b0) begin
            fails++;
            $display("FAIL held_idle: finished=%b, required 0", finished);
        end
    endtask

    task automatic test_reset_mid();
        int base, rb, n, fc;
        fill_random(64, 75, 1'b0);
        out_ready = 1'b1;
        done = 1'b1;
        n = 0;
        while (!(mem_rd && mem_addr == 16'd70) && n < 50) begin tick(); n++; end
        tests++;
        if (!(mem_rd && mem_addr == 16'd70)) begin
            fails++;
            $display("FAIL rst_reach: rd=%b addr=%0d, required 1 and 70", mem_rd, mem_addr);
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({mem_rd, mem_addr, out_data, out_valid, out_idx, out_last, snap_cycles,
             snap_instr, busy, finished} !== '0) begin
            fails++;
            $display("FAIL rst_async: rd=%b addr=%0d data=%0d vld=%b idx=%0d last=%b snap=%0d/%0d busy=%b fin=%b, required all 0",
                     mem_rd, mem_addr, out_data, out_valid, out_idx, out_last, snap_cycles, snap_instr, busy, finished);
        end
        base = acc_data_q.size(); rb = rd_addr_q.size();
        tick(); tick();
        #2 reset_n = 1'b1;
        wait_finished(fc);
        tests++;
        if (rd_addr_q.size() - rb != 12 || rd_addr_q[rb] !== 16'd64) begin
            fails++;
            $display("FAIL rst_restart_addr: reads=%0d first=%0d, required 12 and 64",
                     rd_addr_q.size() - rb, rd_addr_q[rb]);
        end
        tests++;
        if (acc_data_q.size() - base != 3) begin
            fails++;
            $display("FAIL rst_count: %0d words, required 3", acc_data_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (acc_data_q[base+i] !== exp_word(64 + 4*i, 1'b0) || acc_idx_q[base+i] !== 16'(i)) begin
                    fails++;
                    $display("FAIL rst_word%0d: data=%0d idx=%0d, required %0d %0d",
                             i, acc_data_q[base+i], acc_idx_q[base+i], exp_word(64 + 4*i, 1'b0), i);
                end
            end
        end
        done = 1'b0;
        tick(); tick();
    endtask

    task automatic test_glitch();
        int base, n, fc;
        fill_random(64, 75, 1'b0);
        out_ready = 1'b0;
        base = acc_data_q.size();
        done = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        done = 1'b0; tick();
        done = 1'b1; tick(); tick();
        out_ready = 1'b1;
        wait_finished(fc);
        for (int k = 0; k < 8; k++) tick();
        tests++;
        if (acc_data_q.size() - base != 3 || finished !== 1'b1) begin
            fails++;
            $display("FAIL glitch_count: words=%0d finished=%b, required 3 and 1", acc_data_q.size() - base, finished);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (acc_data_q[base+i] !== exp_word(64 + 4*i, 1'b0) || acc_idx_q[base+i] !== 16'(i)) begin
                    fails++;
                    $display("FAIL glitch_word%0d: data=%0d idx=%0d, required %0d %0d",
                             i, acc_data_q[base+i], acc_idx_q[base+i], exp_word(64 + 4*i, 1'b0), i);
                end
            end
        end
        done = 1'b0;
        tick(); tick();
    endtask

    task automatic test_random_ready();
        int base, n;
        for (int pass = 0; pass < 3; pass++) begin
            fill_random(64, 75, 1'b0);
            base = acc_data_q.size();
            done = 1'b1;
            n = 0;
            while (!finished && n < 300) begin
                out_ready = 1'($urandom_range(0, 1));
                tick(); n++;
            end
            out_ready = 1'b1;
            tests++;
            if (acc_data_q.size() - base != 3) begin
                fails++;
                $display("FAIL rand_count%0d: %0d words, required 3", pass, acc_data_q.size() - base);
            end else begin
                for (int i = 0; i < 3; i++) begin
                    tests++;
                    if (acc_data_q[base+i] !== exp_word(64 + 4*i, 1'b0) || acc_idx_q[base+i] !== 16'(i) ||
                        acc_last_q[base+i] !== (i == 2)) begin
                        fails++;
                        $display("FAIL rand_word%0d_%0d: data=%0d idx=%0d last=%b, required %0d %0d %b",
                                 pass, i, acc_data_q[base+i], acc_idx_q[base+i], acc_last_q[base+i],
                                 exp_word(64 + 4*i, 1'b0), i, (i == 2));
                    end
                end
            end
            done = 1'b0;
            tick(); tick();
        end
    endtask

    task automatic test_param_sweep();
        int n;
        logic [15:0] cc, ic;
        fill_random(48, 63, 1'b1);
        cc = 16'($urandom); ic = 16'($urandom);
        clock_count = cc; instr_cnt = ic;
        out_ready2 = 1'b1;
        done2 = 1'b1;
        n = 0;
        while (!finished2 && n < 200) begin tick(); n++; end
        tests++;
        if (finished2 !== 1'b1 || busy2 !== 1'b0) begin
            fails++;
            $display("FAIL sweep_finish: finished=%b busy=%b, required 1 and 0", finished2, busy2);
        end
        tests++;
        if (rd_addr2_q.size() != 16) begin
            fails++;
            $display("FAIL sweep_addr_count: %0d reads, required 16", rd_addr2_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                tests++;
                if (rd_addr2_q[i] !== 16'(48 + i)) begin
                    fails++;
                    $display("FAIL sweep_addr%0d: addr=%0d, required %0d", i, rd_addr2_q[i], 48 + i);
                end
            end
        end
        tests++;
        if (acc_data2_q.size() != 4) begin
            fails++;
            $display("FAIL sweep_count: %0d words, required 4", acc_data2_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (acc_data2_q[i] !== exp_word(48 + 4*i, 1'b1) || acc_idx2_q[i] !== 16'(i) ||
                    acc_last2_q[i] !== (i == 3)) begin
                    fails++;
                    $display("FAIL sweep_word%0d: data=%0d idx=%0d last=%b, required %0d %0d %b",
                             i, acc_data2_q[i], acc_idx2_q[i], acc_last2_q[i], exp_word(48 + 4*i, 1'b1), i, (i == 3));
                end
            end
        end
        tests++;
        if (snap_cycles2 !== cc || snap_instr2 !== ic) begin
            fails++;
            $display("FAIL sweep_snap: cycles=%0d instr=%0d, required %0d %0d", snap_cycles2, snap_instr2, cc, ic);
        end
        done2 = 1'b0;
        tick(); tick();
    endtask

    initial begin
        reset_n = 1'b0; done = 1'b0; done2 = 1'b0;
        clock_count = 16'd0; instr_cnt = 16'd0;
        out_ready = 1'b1; out_ready2 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            mem2[i] = 8'h00;
        end
        test_reset();
        test_nominal();
        test_backpressure();
        test_done_held();
        test_reset_mid();
        test_glitch();
        test_random_ready();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/result_readout.md
# result_readout

Post-run readout stage downstream of `RISCVCPU`. On the rising edge of the CPU's `done`, it snapshots the performance counters `clock_count` and `instr_cnt`. It then walks the result-matrix region of the byte-addressed data memory through a secondary byte read port. Bytes are assembled big-endian into signed 32-bit words, and the M*N2 result words are streamed out on a valid/ready interface for host/UART/display consumers.

## Interface
Parameters:
- `M`, 3, rows of matrix1 / rows of result
- `N`, 4, columns of matrix1 / rows of matrix2
- `N2`, 1, columns of matrix2 / columns of result
- `ADDR_W`, 16, data-memory byte-address width
- Derived localparams: `RES_BASE = M*N*4 + N*N2*4`; `NWORDS = M*N2` (must be ≥1)

Ports:
- `CLOCK_50` in 1: sole clock, all state on its rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `done` in 1: CPU program-complete level
- `clock_count` in 16: CPU cycle counter
- `instr_cnt` in 16: CPU retired-instruction counter
- `mem_rd` out 1: byte read strobe
- `mem_addr` out ADDR_W: byte address
- `mem_rdata` in 8: read byte, valid exactly 1 cycle after the `mem_rd` cycle
- `out_data` out 32: assembled result word
- `out_valid` out 1: word available
- `out_ready` in 1: consumer accepts
- `out_idx` out 16: word index 0..NWORDS-1, row-major (row*N2+col)
- `out_last` out 1: high with `out_valid` on index NWORDS-1
- `snap_cycles` out 16, `snap_instr` out 16: counters captured at the `done` edge
- `busy` out 1: high in RD/WT/PR
- `finished` out 1: high in FIN

## Operation
- Edge detect: `done_q` registered each cycle; `start = done & ~done_q`.
- FSM states and transitions:
  - IDLE: on `start`, load `snap_cycles`/`snap_instr`, set word ptr w=0 and byte ptr b=0, go to RD.
  - RD: drive `mem_rd`=1, `mem_addr = RES_BASE + 4w + b`. Increment b each cycle; after b=3, go to WT.
  - WT: capture the final byte, go to PR.
  - PR: `out_valid`=1. On `out_valid & out_ready`:
    - if w==NWORDS-1, go to FIN;
    - else w++, b=0, go to RD.
  - FIN: `finished`=1. When `done`==0, go to IDLE (permits re-run on the next `done` edge).
- Assembly: the byte returned for issue b lands in `out_data[31-8b -: 8]`, so the byte at lowest address is MSB. Each byte is captured in the cycle after its issue.
- `start` is ignored outside IDLE. Snapshots are not updated outside IDLE.
- `out_data`, `out_idx`, `out_last` hold stable while `out_valid & ~out_ready`.
- Address arithmetic is modulo 2^ADDR_W.
- `out_idx` is zero-extended w.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE; `done_q`=0;
  - all outputs 0: `mem_rd`, `mem_addr`, `out_data`, `out_valid`, `out_idx`, `out_last`, `snap_cycles`, `snap_instr`, `busy`, `finished`.
- Reset mid-operation: everything returns to reset values, the in-flight read is dropped, and no partial word is presented.
  - If `done` is still high after reset release, `done_q`=0 makes the next cycle a `start`.
- Start latency: `done` rises at edge t → RD from t+1. Reads issue at t+1..t+4, last byte captured at t+5, `out_valid`=1 from t+6.
- Per word: 6 cycles minimum (4 RD, 1 WT, ≥1 PR). Zero-stall NWORDS=3 run: FIN entered 18 cycles after the first RD.
- `mem_rd` is high only in RD.
- `out_valid`, `busy`, `finished` are registered state decodes (no combinational path from `out_ready`).

## Test plan
- Nominal 3×4×1:
  - Stimulus: memory model preloaded so bytes 64..75 = 00 00 00 1E, FF FF FF F6, 00 00 01 00; `done` pulsed high with `clock_count`=412, `instr_cnt`=150; `out_ready`=1.
  - Required: words 30, -10, 256 at idx 0,1,2; `out_last` only on idx 2; `snap_cycles`=412, `snap_instr`=150; `finished`=1.
  - Check addresses 64..75 in order, `out_valid` rising 6 cycles after `done`.
- Backpressure: hold `out_ready`=0 for 7 cycles on idx 1 → `out_valid` stays high, data/idx unchanged, no `mem_rd` during the stall, idx 2 follows the release.
- `done` held high throughout and toggled counters after start → exactly one pass; snapshots frozen at the first-edge values. Dropping then re-raising `done` after FIN → a second full pass.
- Reset mid-RD:
  - Stimulus: assert `reset_n`=0 at byte 2 of word 1.
  - Required: all outputs 0 asynchronously. With `done` still high at release, a fresh pass restarts from idx 0 at `RES_BASE`=64.
- Parameter sweep M=2, N=3, N2=2 → `RES_BASE`=48, 4 words read from bytes 48..63, idx 0..3 row-major, `out_last` on idx 3.
- Spurious `done` glitch (low then high) while in PR → ignored; the sequence completes normally.
